score_window_buffer: RTL and testbench

Streaming 3x3 window generator that sits directly upstream of `NonmaxSuppression` in the corner-detection pipeline. It accepts one signed corner score per cycle in raster order and buffers two full image rows internally. For every pixel whose complete 3x3 neighbourhood lies inside the image, it presents that neighbourhood as a registered window with the centre coordinates attached. The window port shape matches the `window` input of `NonmaxSuppression`, so the two blocks connect directly.

---
 rtl/score_window_buffer.sv | 196 +++++++++++++++++++
 tb/tb_score_window_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : score_window_buffer
//  Purpose  : Streaming 3x3 window generator for signed corner scores.
//             Accepts one score per cycle in raster order, keeps the two
//             previous image rows in line buffers, and emits a registered
//             3x3 neighbourhood (with centre coordinates) for every pixel
//             whose full neighbourhood lies inside the image.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         : rising-edge clock
//    rst_n       : asynchronous active-low reset
//    in_valid    : in_score is accepted on this edge (no backpressure)
//    in_sof      : qualified by in_valid, marks pixel (0,0) of a frame
//    in_score    : signed score of the current pixel
//    out_valid   : window / coordinates / eof valid this cycle
//    out_window  : 3x3 window as [row][col]; [0][0] is top-left, [1][1] centre
//    out_x       : centre column of the window
//    out_y       : centre row of the window
//    out_eof     : set with the last window of a frame
// ============================================================================
module score_window_buffer #(
    parameter int  DATA_BITS    = 8,
    parameter int  IMAGE_WIDTH  = 640,
    parameter int  IMAGE_HEIGHT = 480,
    localparam int XW           = $clog2(IMAGE_WIDTH),
    localparam int YW           = $clog2(IMAGE_HEIGHT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic                        in_sof,
    input  logic signed [DATA_BITS-1:0] in_score,
    output logic                        out_valid,
    output logic signed [DATA_BITS-1:0] out_window [3][3],
    output logic        [XW-1:0]        out_x,
    output logic        [YW-1:0]        out_y,
    output logic                        out_eof
);

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam logic [XW-1:0] C_X_LAST = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] C_Y_LAST = YW'(IMAGE_HEIGHT - 1);
    localparam logic [XW-1:0] C_X_TWO  = XW'(2);
    localparam logic [YW-1:0] C_Y_TWO  = YW'(2);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                      state_q, state_d;
    logic [XW-1:0]               x_q, x_d;
    logic [YW-1:0]               y_q, y_d;
    logic signed [DATA_BITS-1:0] win_q [3][3];
    logic signed [DATA_BITS-1:0] win_d [3][3];
    logic signed [DATA_BITS-1:0] out_window_q [3][3];
    logic signed [DATA_BITS-1:0] out_window_d [3][3];
    logic [XW-1:0]               out_x_q, out_x_d;
    logic [YW-1:0]               out_y_q, out_y_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_eof_q, out_eof_d;

    // Line buffers: lb0 holds row y-1, lb1 holds row y-2. Not reset; every
    // address is rewritten before any window that reads it can be emitted.
    logic signed [DATA_BITS-1:0] lb0_q [IMAGE_WIDTH];
    logic signed [DATA_BITS-1:0] lb1_q [IMAGE_WIDTH];

    // ------------------------------------------------------------------
    // Pixel qualification and effective coordinates
    // ------------------------------------------------------------------
    logic                        accept;
    logic [XW-1:0]               pix_x;
    logic [YW-1:0]               pix_y;
    logic                        last_col;
    logic                        last_row;
    logic                        emit;
    logic signed [DATA_BITS-1:0] rd_lb0;
    logic signed [DATA_BITS-1:0] rd_lb1;

    // An in_sof pixel is accepted in any state and is forced to (0,0), so a
    // mid-frame sof simply restarts the raster scan.
    assign accept   = in_valid && (in_sof || (state_q == ACTIVE));
    assign pix_x    = in_sof ? '0 : x_q;
    assign pix_y    = in_sof ? '0 : y_q;
    assign last_col = (pix_x == C_X_LAST);
    assign last_row = (pix_y == C_Y_LAST);
    assign emit     = accept && (pix_x >= C_X_TWO) && (pix_y >= C_Y_TWO);

    // Read-before-write: these reads see the contents before this edge's
    // update of the same address.
    assign rd_lb0   = lb0_q[pix_x];
    assign rd_lb1   = lb1_q[pix_x];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        win_d        = win_q;
        out_window_d = out_window_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_valid_d  = 1'b0;
        out_eof_d    = 1'b0;

        if (accept) begin
            // Shift window columns left, new right column from the line
            // buffers (older rows on top) and the incoming score.
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = rd_lb1;
            win_d[1][2] = rd_lb0;
            win_d[2][2] = in_score;

            if (last_col) begin
                x_d = '0;
                y_d = last_row ? '0 : (pix_y + YW'(1));
            end else begin
                x_d = pix_x + XW'(1);
                y_d = pix_y;
            end

            state_d = (last_col && last_row) ? WAIT_SOF : ACTIVE;
        end

        // Output registers only load on an emitted window so that they hold
        // the last window through gaps and border pixels.
        if (emit) begin
            out_valid_d  = 1'b1;
            out_window_d = win_d;
            out_x_d      = pix_x - XW'(1);
            out_y_d      = pix_y - YW'(1);
            out_eof_d    = last_col && last_row;
        end
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_SOF;
            x_q         <= '0;
            y_q         <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c]        <= '0;
                    out_window_q[r][c] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            win_q        <= win_d;
            out_window_q <= out_window_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_valid_q  <= out_valid_d;
            out_eof_q    <= out_eof_d;
        end
    end

    // ------------------------------------------------------------------
    // Line-buffer storage (no reset, RAM-style)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[pix_x] <= rd_lb0;
            lb0_q[pix_x] <= in_score;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid  = out_valid_q;
    assign out_window = out_window_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_eof    = out_eof_q;

endmodule
`default_nettype wire

// File: tb/tb_score_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_window_buffer
//  Purpose  : Self-checking bench for score_window_buffer (5x4 image, 8-bit
//             scores). Stimulus pushes expected windows into a queue; a
//             negedge monitor pops and compares each presented window.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_window_buffer;

    localparam int DB = 8;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    typedef struct {
        int w [9];
        int x;
        int y;
        bit eof;
        int stamp;
    } exp_t;

    logic                 clk      = 1'b0;
    logic                 rst_n    = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_sof   = 1'b0;
    logic signed [DB-1:0] in_score = '0;
    logic                 out_valid;
    logic signed [DB-1:0] out_window [3][3];
    logic [XW-1:0]        out_x;
    logic [YW-1:0]        out_y;
    logic                 out_eof;

    score_window_buffer #(
        .DATA_BITS   (DB),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_score  (in_score),
        .out_valid (out_valid),
        .out_window(out_window),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   checks = 0;
    int   errors = 0;
    exp_t q [$];
    exp_t last_win;
    bit   have_last  = 1'b0;
    bit   hold_mode  = 1'b0;
    bit   prev_valid = 1'b0;

    // Compare window and coordinates only (used for both pops and holds).
    function automatic bit win_match(exp_t e);
        bit ok = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (int'(out_window[r][c]) != e.w[r*3+c]) ok = 1'b0;
        if (int'(out_x) != e.x) ok = 1'b0;
        if (int'(out_y) != e.y) ok = 1'b0;
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_window: got window x=%0d y=%0d eof=%0d at cycle %0d, required no window",
                         out_x, out_y, out_eof, cyc);
            end else begin
                e = q.pop_front();
                if (!win_match(e) || (out_eof != e.eof) || (cyc != e.stamp)) begin
                    errors++;
                    $display("FAIL window: got x=%0d y=%0d eof=%0d cyc=%0d top=%0d,%0d,%0d mid=%0d,%0d,%0d bot=%0d,%0d,%0d ; required x=%0d y=%0d eof=%0d cyc=%0d top=%0d,%0d,%0d mid=%0d,%0d,%0d bot=%0d,%0d,%0d",
                             out_x, out_y, out_eof, cyc,
                             out_window[0][0], out_window[0][1], out_window[0][2],
                             out_window[1][0], out_window[1][1], out_window[1][2],
                             out_window[2][0], out_window[2][1], out_window[2][2],
                             e.x, e.y, e.eof, e.stamp,
                             e.w[0], e.w[1], e.w[2], e.w[3], e.w[4], e.w[5], e.w[6], e.w[7], e.w[8]);
                end
                last_win  = e;
                have_last = 1'b1;
            end
            if (hold_mode) begin
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL back_to_back: out_valid high on consecutive cycles at cycle %0d, required isolated pulses", cyc);
                end
            end
        end else if (hold_mode && have_last) begin
            checks++;
            if (!win_match(last_win)) begin
                errors++;
                $display("FAIL hold: got x=%0d y=%0d centre=%0d at cycle %0d, required held x=%0d y=%0d centre=%0d",
                         out_x, out_y, out_window[1][1], cyc, last_win.x, last_win.y, last_win.w[4]);
            end
        end
        prev_valid = out_valid;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic check_zero(input string name);
        bit ok = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (out_window[r][c] != '0) ok = 1'b0;
        checks++;
        if (out_valid || out_eof || (out_x != '0) || (out_y != '0) || !ok) begin
            errors++;
            $display("FAIL %s: got valid=%0d eof=%0d x=%0d y=%0d centre=%0d, required all zero",
                     name, out_valid, out_eof, out_x, out_y, out_window[1][1]);
        end
    endtask

    // Drive one pixel (called at posedge+1) and, if a window is due, queue the
    // expected neighbourhood of score(x,y) = sign*(10y+x) around (x-1,y-1).
    task automatic drive_pix(input bit sof, input int sign, input int px, input int py,
                             input bit expect_win);
        exp_t e;
        in_valid = 1'b1;
        in_sof   = sof;
        in_score = DB'(sign * (10 * py + px));
        if (expect_win) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.w[r*3+c] = sign * (10 * (py - 2 + r) + (px - 2 + c));
            e.x     = px - 1;
            e.y     = py - 1;
            e.eof   = (px == W - 1) && (py == H - 1);
            e.stamp = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Send raster pixels first..last; sof on the first one if requested.
    task automatic send_frame(input int sign, input int gap, input bit sof,
                              input bit expect_win, input int first, input int last);
        for (int idx = first; idx <= last; idx++) begin
            int px = idx % W;
            int py = idx / W;
            drive_pix(sof && (idx == first), sign, px, py,
                      expect_win && (px >= 2) && (py >= 2));
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held with active inputs, then pixels without sof
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_score = 8'sd55;
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b1;
        send_frame(1, 0, 1'b0, 1'b0, 0, 4);
        repeat (3) begin @(posedge clk); #1; end

        // 2: full frame back-to-back
        send_frame(1, 0, 1'b1, 1'b1, 0, W * H - 1);
        repeat (3) begin @(posedge clk); #1; end

        // 3: in_valid every third cycle, with hold / isolation checks
        hold_mode = 1'b1;
        send_frame(1, 2, 1'b1, 1'b1, 0, W * H - 1);
        repeat (3) begin @(posedge clk); #1; end
        hold_mode = 1'b0;

        // 4: aborted partial frame, then a negative-score frame
        send_frame(1, 0, 1'b1, 1'b0, 0, 6);
        send_frame(-1, 0, 1'b1, 1'b1, 0, W * H - 1);
        repeat (2) begin @(posedge clk); #1; end

        // 5: stray pixels after a complete frame, then a normal frame
        send_frame(1, 0, 1'b0, 1'b0, 0, 3);
        send_frame(1, 0, 1'b1, 1'b1, 0, W * H - 1);
        repeat (2) begin @(posedge clk); #1; end

        // 6: asynchronous reset while pixel (3,2) is presented
        send_frame(1, 0, 1'b1, 1'b1, 0, 12);
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_score = 8'sd23;
        #6;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(1, 0, 1'b0, 1'b0, 14, W * H - 1);
        repeat (2) begin @(posedge clk); #1; end
        send_frame(1, 0, 1'b1, 1'b1, 0, W * H - 1);

        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_windows: %0d expected windows never appeared, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
